// File: rtl/jtag_probe_shifter_pkg.sv
// Shared constants for the JTAG probe shifter: field widths and FSM encodings.
package jtag_probe_shifter_pkg;
    localparam int W_LEN   = 5;
    localparam int W_SHIFT = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOW  = 2'd1;
    localparam logic [1:0] ST_HIGH = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;
endpackage

// File: rtl/jtag_probe_shifter_tick.sv
// Loadable down-counter; tick marks the last clk cycle of a TCK half-period.
module jtag_probe_tick #(
    parameter int W_DIV = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [W_DIV-1:0] div,
    output logic             tick
);
    logic [W_DIV-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else if (load)
            cnt_q <= div;
        else if (cnt_q != '0)
            cnt_q <= cnt_q - 1'b1;
    end

    assign tick = (cnt_q == '0);
endmodule

// File: rtl/jtag_probe_shifter.sv
// Host-side JTAG initiator: shifts 1-32 bits of TMS/TDI and optionally returns TDO.
module jtag_probe_shifter
    import jtag_probe_shifter_pkg::*;
#(
    parameter int W_DIV = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [W_DIV-1:0]   clk_div,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [W_LEN-1:0]   cmd_len,
    input  logic [W_SHIFT-1:0] cmd_tms,
    input  logic [W_SHIFT-1:0] cmd_tdi,
    input  logic               cmd_rsp,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [W_SHIFT-1:0] rsp_tdo,
    output logic               busy,
    output logic               tck,
    output logic               tms,
    output logic               tdi,
    input  logic               tdo
);
    logic [1:0]         state_q, state_d;
    logic [W_LEN-1:0]   len_q, idx_q;
    logic [W_SHIFT-1:0] tms_sr_q, tdi_sr_q, cap_q;
    logic [W_DIV-1:0]   div_q;
    logic               rsp_en_q;
    logic               tck_q, tms_q, tdi_q, ready_q, rsp_valid_q, busy_q;
    logic               accept, last_bit, tick, load;

    assign accept   = cmd_valid && (state_q == ST_IDLE);
    assign last_bit = (idx_q == len_q);

    // The divisor is captured at accept, so the first phase must load it straight from the port.
    jtag_probe_tick #(.W_DIV(W_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .div  (accept ? clk_div : div_q),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            ST_IDLE: if (accept) begin
                state_d = ST_LOW;
                load    = 1'b1;
            end
            ST_LOW: if (tick) begin
                state_d = ST_HIGH;
                load    = 1'b1;
            end
            ST_HIGH: if (tick) begin
                load = 1'b1;
                if (!last_bit)     state_d = ST_LOW;
                else if (rsp_en_q) state_d = ST_RESP;
                else               state_d = ST_IDLE;
            end
            ST_RESP: if (rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            idx_q       <= '0;
            tms_sr_q    <= '0;
            tdi_sr_q    <= '0;
            cap_q       <= '0;
            div_q       <= '0;
            rsp_en_q    <= 1'b0;
            tck_q       <= 1'b0;
            tms_q       <= 1'b1;
            tdi_q       <= 1'b0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tck_q       <= (state_d == ST_HIGH);
            ready_q     <= (state_d == ST_IDLE);
            rsp_valid_q <= (state_d == ST_RESP);
            busy_q      <= (state_d != ST_IDLE);
            if (accept) begin
                len_q    <= cmd_len;
                idx_q    <= '0;
                div_q    <= clk_div;
                rsp_en_q <= cmd_rsp;
                cap_q    <= '0;
                tms_q    <= cmd_tms[0];
                tdi_q    <= cmd_tdi[0];
                tms_sr_q <= {1'b0, cmd_tms[W_SHIFT-1:1]};
                tdi_sr_q <= {1'b0, cmd_tdi[W_SHIFT-1:1]};
            end
            // TDO is sampled before the falling edge; pins only move to the next bit if one remains.
            if (state_q == ST_HIGH && tick) begin
                cap_q[idx_q] <= tdo;
                if (!last_bit) begin
                    idx_q    <= idx_q + 1'b1;
                    tms_q    <= tms_sr_q[0];
                    tdi_q    <= tdi_sr_q[0];
                    tms_sr_q <= {1'b0, tms_sr_q[W_SHIFT-1:1]};
                    tdi_sr_q <= {1'b0, tdi_sr_q[W_SHIFT-1:1]};
                end
            end
        end
    end

    assign tck       = tck_q;
    assign tms       = tms_q;
    assign tdi       = tdi_q;
    assign cmd_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign busy      = busy_q;
    assign rsp_tdo   = cap_q;
endmodule

// File: tb/tb_jtag_probe_shifter.sv
// Directed, table-driven bench for jtag_probe_shifter with hand-computed expectations.
module tb_jtag_probe_shifter;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  clk_div;
    logic        cmd_valid, cmd_ready, cmd_rsp;
    logic [4:0]  cmd_len;
    logic [31:0] cmd_tms, cmd_tdi, rsp_tdo;
    logic        rsp_valid, rsp_ready, busy, tck, tms, tdi, tdo;
    int          tdo_mode;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    // 0: loopback tdo=tdi, 1: tdo tied high, 2: tdo tied low
    always_comb tdo = (tdo_mode == 0) ? tdi : (tdo_mode == 1);

    jtag_probe_shifter #(.W_DIV(8)) dut (
        .clk(clk), .rst(rst), .clk_div(clk_div),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
        .cmd_tms(cmd_tms), .cmd_tdi(cmd_tdi), .cmd_rsp(cmd_rsp),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tdo(rsp_tdo),
        .busy(busy), .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
    );

    typedef struct {
        logic [4:0]  len;
        logic [31:0] tms;
        logic [31:0] tdi;
        logic        rsp;
        logic [7:0]  div;
        int          tdo_mode;
        int          exp_pulses;
        int          exp_width;
        int          exp_done;
        logic [31:0] exp_tdo;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic run_vec(input int id, input vec_t v);
        int   done = 0;
        int   pulses = 0;
        int   wmin = 1000;
        int   wmax = 0;
        int   run = 0;
        int   first = -1;
        logic prev = 1'b0;
        logic pins_ok = 1'b1;
        @(negedge clk);
        check($sformatf("v%0d ready_pre", id), {31'd0, cmd_ready}, 32'd1);
        cmd_len = v.len; cmd_tms = v.tms; cmd_tdi = v.tdi; cmd_rsp = v.rsp;
        clk_div = v.div; tdo_mode = v.tdo_mode; cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        clk_div = 8'hFF;  // must not affect the command in flight
        for (int c = 1; c <= 400 && done == 0; c++) begin
            @(negedge clk);
            if (c == 1) check($sformatf("v%0d busy", id), {31'd0, busy}, 32'd1);
            if (tck) begin
                if (!prev) begin
                    pulses++;
                    if (first < 0) first = c;
                end
                run++;
                if (pulses < 1 || pulses > 32) pins_ok = 1'b0;
                else if (tms !== v.tms[pulses-1] || tdi !== v.tdi[pulses-1]) pins_ok = 1'b0;
            end else begin
                if (prev) begin
                    if (run < wmin) wmin = run;
                    if (run > wmax) wmax = run;
                end
                run = 0;
            end
            prev = tck;
            if (rsp_valid || cmd_ready) done = c;
        end
        check($sformatf("v%0d done_cycle", id), done, v.exp_done);
        check($sformatf("v%0d pulses", id), pulses, v.exp_pulses);
        check($sformatf("v%0d wmin", id), wmin, v.exp_width);
        check($sformatf("v%0d wmax", id), wmax, v.exp_width);
        check($sformatf("v%0d first_high", id), first, v.div + 2);
        check($sformatf("v%0d pins", id), {31'd0, pins_ok}, 32'd1);
        check($sformatf("v%0d rsp_valid", id), {31'd0, rsp_valid}, {31'd0, v.rsp});
        check($sformatf("v%0d ready_end", id), {31'd0, cmd_ready}, {31'd0, !v.rsp});
        check($sformatf("v%0d tms_hold", id), {31'd0, tms}, {31'd0, v.tms[v.len]});
        check($sformatf("v%0d tdi_hold", id), {31'd0, tdi}, {31'd0, v.tdi[v.len]});
        if (v.rsp) begin
            check($sformatf("v%0d rsp_tdo", id), rsp_tdo, v.exp_tdo);
            rsp_ready = 1'b1;
            @(posedge clk);
            #1;
            rsp_ready = 1'b0;
            @(negedge clk);
            check($sformatf("v%0d idle_ready", id), {31'd0, cmd_ready}, 32'd1);
            check($sformatf("v%0d idle_busy", id), {31'd0, busy}, 32'd0);
            check($sformatf("v%0d idle_rspv", id), {31'd0, rsp_valid}, 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //               len    tms           tdi           rsp   div  mode pul wid done  exp_tdo
        vecs[0] = '{5'd3,  32'h0,        32'hA,        1'b1, 8'd0, 0, 4,  1, 9,   32'h0000000A};
        vecs[1] = '{5'd4,  32'h1F,       32'h0,        1'b0, 8'd1, 2, 5,  2, 21,  32'h0};
        vecs[2] = '{5'd31, 32'h0,        32'h0,        1'b1, 8'd3, 1, 32, 4, 257, 32'hFFFFFFFF};
        vecs[3] = '{5'd0,  32'h0,        32'h1,        1'b1, 8'd0, 0, 1,  1, 3,   32'h00000001};
        vecs[4] = '{5'd7,  32'h3C,       32'hFFFFFF5A, 1'b1, 8'd2, 0, 8,  3, 49,  32'h0000005A};
        vecs[5] = '{5'd15, 32'h8001,     32'hFFFFFFFF, 1'b1, 8'd0, 2, 16, 1, 33,  32'h0};

        rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0; clk_div = 8'd0;
        cmd_len = '0; cmd_tms = '0; cmd_tdi = '0; cmd_rsp = 1'b0; tdo_mode = 2;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst tck", {31'd0, tck}, 32'd0);
        check("rst tms", {31'd0, tms}, 32'd1);
        check("rst tdi", {31'd0, tdi}, 32'd0);
        check("rst ready", {31'd0, cmd_ready}, 32'd1);
        check("rst rspv", {31'd0, rsp_valid}, 32'd0);
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst tdo", rsp_tdo, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // Backpressure: 2-bit loopback, tdi=0b10 -> response 0x2 on cycle 5.
        begin
            int got_rsp = 0;
            @(negedge clk);
            cmd_len = 5'd1; cmd_tms = 32'h0; cmd_tdi = 32'h2; cmd_rsp = 1'b1;
            clk_div = 8'd0; tdo_mode = 0; cmd_valid = 1'b1;
            @(posedge clk);
            #1 cmd_valid = 1'b0;
            for (int c = 1; c <= 50 && got_rsp == 0; c++) begin
                @(negedge clk);
                if (rsp_valid) got_rsp = c;
            end
            check("bp rsp_cycle", got_rsp, 5);
            for (int c = 0; c < 10; c++) begin
                if (c == 3) begin
                    cmd_len = 5'd0; cmd_tdi = 32'h1; cmd_tms = 32'h1; cmd_valid = 1'b1;
                end
                if (c == 6) cmd_valid = 1'b0;
                check($sformatf("bp tdo%0d", c), rsp_tdo, 32'h2);
                check($sformatf("bp ready%0d", c), {31'd0, cmd_ready}, 32'd0);
                check($sformatf("bp rspv%0d", c), {31'd0, rsp_valid}, 32'd1);
                check($sformatf("bp tck%0d", c), {31'd0, tck}, 32'd0);
                @(negedge clk);
            end
            rsp_ready = 1'b1;
            @(posedge clk);
            #1 rsp_ready = 1'b0;
            @(negedge clk);
            check("bp idle_ready", {31'd0, cmd_ready}, 32'd1);
            check("bp idle_busy", {31'd0, busy}, 32'd0);
            check("bp idle_rspv", {31'd0, rsp_valid}, 32'd0);
        end

        // Reset mid-shift: d=1, bit 2 HIGH occupies cycles 11-12.
        begin
            int seen = 0;
            @(negedge clk);
            cmd_len = 5'd7; cmd_tms = 32'h0; cmd_tdi = 32'hFF; cmd_rsp = 1'b1;
            clk_div = 8'd1; tdo_mode = 0; cmd_valid = 1'b1;
            @(posedge clk);
            #1 cmd_valid = 1'b0;
            for (int c = 1; c <= 11; c++) @(negedge clk);
            check("mid tck_high", {31'd0, tck}, 32'd1);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check("mid tck", {31'd0, tck}, 32'd0);
            check("mid tms", {31'd0, tms}, 32'd1);
            check("mid tdi", {31'd0, tdi}, 32'd0);
            check("mid busy", {31'd0, busy}, 32'd0);
            for (int c = 0; c < 60; c++) begin
                @(negedge clk);
                if (rsp_valid || tck) seen++;
            end
            check("mid no_rsp", seen, 0);
            check("mid ready", {31'd0, cmd_ready}, 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
